// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data-bus controller: opcodes, FSM states
// and the lane/alignment helpers used by both the controller and its aligner.
package mips_mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned BE_W   = 4;

  localparam logic [OP_W-1:0] OP_LB  = 6'h20;
  localparam logic [OP_W-1:0] OP_LH  = 6'h21;
  localparam logic [OP_W-1:0] OP_LWL = 6'h22;
  localparam logic [OP_W-1:0] OP_LW  = 6'h23;
  localparam logic [OP_W-1:0] OP_LBU = 6'h24;
  localparam logic [OP_W-1:0] OP_LHU = 6'h25;
  localparam logic [OP_W-1:0] OP_LWR = 6'h26;
  localparam logic [OP_W-1:0] OP_SB  = 6'h28;
  localparam logic [OP_W-1:0] OP_SH  = 6'h29;
  localparam logic [OP_W-1:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Unknown opcodes under a load/store flag degrade to a full-word access.
  function automatic logic [OP_W-1:0] normalize_op(input logic is_load,
                                                   input logic [OP_W-1:0] op);
    logic [OP_W-1:0] res;
    res = is_load ? OP_LW : OP_SW;
    if (is_load) begin
      case (op)
        OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: res = op;
        default: res = OP_LW;
      endcase
    end else begin
      case (op)
        OP_SB, OP_SH, OP_SW: res = op;
        default: res = OP_SW;
      endcase
    end
    return res;
  endfunction

  function automatic logic misaligned(input logic [OP_W-1:0] op, input logic [1:0] a);
    logic res;
    res = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: res = a[0];
      OP_LW, OP_SW:         res = (a != 2'd0);
      default:              res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic [BE_W-1:0] lane_mask(input logic [OP_W-1:0] op, input logic [1:0] a);
    logic [BE_W-1:0] res;
    res = 4'b1111;
    case (op)
      OP_SB:   res = 4'b0001 << a;
      OP_SH:   res = a[1] ? 4'b1100 : 4'b0011;
      default: res = 4'b1111;
    endcase
    return res;
  endfunction

  function automatic logic [DATA_W-1:0] store_lanes(input logic [OP_W-1:0] op,
                                                    input logic [DATA_W-1:0] rt);
    logic [DATA_W-1:0] res;
    res = rt;
    case (op)
      OP_SB:   res = {4{rt[7:0]}};
      OP_SH:   res = {2{rt[15:0]}};
      default: res = rt;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/load_data_aligner.sv
// Combinational load formatter: byte/halfword extraction with sign or zero
// extension, and the unaligned lwl/lwr merge with the old register value.
module load_data_aligner
  import mips_mem_pkg::*;
(
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] rt,
  input  logic [OP_W-1:0]   op,
  input  logic [1:0]        a,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [4:0]  lwl_shift;
  logic [4:0]  lwr_shift;

  assign sel_byte  = d[{a, 3'b000} +: 8];
  assign sel_half  = d[{a[1], 4'b0000} +: 16];
  // 8*(3-a) is simply the inverted offset scaled to bytes.
  assign lwl_shift = {~a, 3'b000};
  assign lwr_shift = {a, 3'b000};

  always_comb begin
    result = d;
    case (op)
      OP_LB:   result = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  result = {24'h0, sel_byte};
      OP_LH:   result = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  result = {16'h0, sel_half};
      OP_LWL:  result = (d << lwl_shift) | (rt & ~(32'hFFFF_FFFF << lwl_shift));
      OP_LWR:  result = (d >> lwr_shift) | (rt & ~(32'hFFFF_FFFF >> lwr_shift));
      default: result = d;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// MEM-stage controller: issues one Avalon-MM read or write per load/store,
// stalls the pipeline until it completes, and returns the formatted load data.
module memory_access_stage
  import mips_mem_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT  = 0,
  parameter int unsigned TIMEOUT_WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memory_to_register_memory,
  input  logic              memory_write_memory,
  input  logic [OP_W-1:0]   op_memory,
  input  logic [DATA_W-1:0] ALU_output_memory,
  input  logic [DATA_W-1:0] write_data_memory,
  output logic [DATA_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [BE_W-1:0]   avm_byteenable,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic [DATA_W-1:0] read_data_memory,
  output logic              memory_stall,
  output logic              address_error,
  output logic              bus_timeout
);

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LIMIT = TIMEOUT_WIDTH'(WAIT_TIMEOUT);
  localparam logic [TIMEOUT_WIDTH-1:0] COUNT_MAX     = '1;

  state_t                   state;
  logic [OP_W-1:0]          op_q;
  logic [1:0]               a_q;
  logic [DATA_W-1:0]        rt_q;
  logic [TIMEOUT_WIDTH-1:0] wait_cnt;
  logic [TIMEOUT_WIDTH-1:0] wait_next;
  logic                     pending;
  logic                     timeout_hit;
  logic [OP_W-1:0]          op_eff;
  logic [1:0]               a;
  logic [DATA_W-1:0]        load_result;

  assign pending      = memory_to_register_memory | memory_write_memory;
  assign a            = ALU_output_memory[1:0];
  assign op_eff       = normalize_op(memory_to_register_memory, op_memory);
  assign memory_stall = pending && (state != DONE);
  assign wait_next    = (wait_cnt == COUNT_MAX) ? wait_cnt : wait_cnt + TIMEOUT_WIDTH'(1);
  assign timeout_hit  = (WAIT_TIMEOUT != 0) && (wait_next >= TIMEOUT_LIMIT);

  load_data_aligner u_aligner (
    .d      (avm_readdata),
    .rt     (rt_q),
    .op     (op_q),
    .a      (a_q),
    .result (load_result)
  );

  // Access sequencer; the pipeline advances on the edge that leaves DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      op_q             <= '0;
      a_q              <= '0;
      rt_q             <= '0;
      wait_cnt         <= '0;
      avm_address      <= '0;
      avm_read         <= 1'b0;
      avm_write        <= 1'b0;
      avm_byteenable   <= '0;
      avm_writedata    <= '0;
      read_data_memory <= '0;
      address_error    <= 1'b0;
      bus_timeout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pending) begin
            op_q     <= op_eff;
            a_q      <= a;
            rt_q     <= write_data_memory;
            wait_cnt <= '0;
            if (misaligned(op_eff, a)) begin
              state            <= DONE;
              address_error    <= 1'b1;
              read_data_memory <= '0;
            end else begin
              state          <= REQ;
              avm_address    <= {ALU_output_memory[DATA_W-1:2], 2'b00};
              avm_read       <= memory_to_register_memory;
              avm_write      <= ~memory_to_register_memory;
              avm_byteenable <= lane_mask(op_eff, a);
              if (!memory_to_register_memory) begin
                avm_writedata <= store_lanes(op_eff, write_data_memory);
              end
            end
          end
        end
        REQ: begin
          if (!avm_waitrequest) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            if (avm_read) begin
              read_data_memory <= load_result;
            end
            state <= DONE;
          end else if (timeout_hit) begin
            avm_read         <= 1'b0;
            avm_write        <= 1'b0;
            bus_timeout      <= 1'b1;
            read_data_memory <= '0;
            state            <= DONE;
          end else begin
            wait_cnt <= wait_next;
          end
        end
        DONE: begin
          address_error <= 1'b0;
          bus_timeout   <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- MEM-stage controller, directly downstream of the EX/MEM pipeline register.
- Turns the registered load/store control, opcode, address and store data into transactions on an Avalon-MM style data bus with waitrequest.
- Aligns and merges load data and returns it to the MEM/WB register.
- Stalls the pipeline until each access completes.

Parameters:
- WAIT_TIMEOUT, default 0: max cycles in REQ before abort. 0 disables the timeout.
- TIMEOUT_WIDTH, default 16: width of the wait counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- memory_to_register_memory  in  1  load instruction in MEM
- memory_write_memory  in  1  store instruction in MEM
- op_memory  in  6  opcode of MEM instruction
- ALU_output_memory  in  32  effective byte address
- write_data_memory  in  32  rt value (store data / lwl-lwr merge source)
- avm_address  out  32  word address (byte address with [1:0]=0)
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_byteenable  out  4  lane enables
- avm_writedata  out  32  lane-replicated store data
- avm_readdata  in  32  read data, valid in the cycle waitrequest is low during a read
- avm_waitrequest  in  1  slave not ready
- read_data_memory  out  32  aligned/extended load result, to MEM/WB
- memory_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB
- address_error  out  1  one-cycle pulse on misaligned access
- bus_timeout  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset:
  - reset is asynchronous, active-high; clock is clk.
  - Reset forces state IDLE; avm_read, avm_write, address_error, bus_timeout = 0; avm_address, avm_writedata, read_data_memory = 0; avm_byteenable = 0; wait counter = 0.
  - Reset mid-REQ drops the request immediately; the transaction is abandoned.
- Opcodes handled:
  - Loads: lb 0x20, lh 0x21, lwl 0x22, lw 0x23, lbu 0x24, lhu 0x25, lwr 0x26.
  - Stores: sb 0x28, sh 0x29, sw 0x2B.
  - Any other op with the load/store flag set is treated as lw/sw.
- Byte order is little-endian: byte k of the word (a = address[1:0]) is on bits [8k+7:8k].
- States: IDLE, REQ, DONE.
  - IDLE: on a pending op (load or store flag set), go to REQ.
    - Registered avm_* outputs are set on that edge.
    - Misaligned access (lh/lhu/sh with a[0]=1; lw/sw with a≠0) instead goes to DONE with address_error=1, read_data_memory=0 and no bus access.
  - REQ: request outputs held stable while avm_waitrequest=1.
    - On waitrequest=0: the load result is captured into read_data_memory, read/write deassert, go to DONE.
    - If WAIT_TIMEOUT≠0 and the counter reaches WAIT_TIMEOUT: drop the request, bus_timeout=1, read_data_memory=0, go to DONE.
  - DONE: always go to IDLE. Error pulses clear.
- memory_stall is combinational: (load|store) && state≠DONE.
  - The pipeline advances on the DONE edge.
  - A memory op costs 3 cycles at zero wait, 3+N with N wait cycles.
  - Back-to-back memory ops re-enter via IDLE.
- Non-memory instructions: no stall, no bus activity, read_data_memory holds its value.
- Byte enables:
  - sb: 1<<a.
  - sh: 0011 for a=0, 1100 for a=2.
  - sw: 1111.
  - Loads: 1111.
- Store data:
  - sb replicates rt[7:0] to all four lanes.
  - sh replicates rt[15:0] to both halves.
  - sw passes rt unchanged.
- Load data, d = readdata:
  - lb/lbu: byte a, sign/zero extended.
  - lh/lhu: halfword a[1], sign/zero extended.
  - lw: d.
  - lwl: (d << 8(3-a)) merged with rt's low 3-a bytes.
  - lwr: (d >> 8a) merged with rt's high a bytes.
- avm_read and avm_write are never both 1. No request is ever issued in IDLE or DONE.
- The wait counter resets on entry to REQ and saturates at its maximum value.

Decomposition:
- Shared package mips_mem_pkg holds:
  - opcode localparams (OP_LB … OP_SW);
  - the state enum (IDLE/REQ/DONE);
  - lane-mask helper functions.
- One sub-module, load_data_aligner: combinational (d, rt, op, a) → result. It covers extension and lwl/lwr merging and is reusable by the verification model.

Test Plan:
- sw 0xDEADBEEF @0x100, waitrequest=0 → avm_write=1 for 1 cycle, address 0x100, byteenable 1111, memory_stall high 2 cycles then low.
- lb @0x103, readdata 0x80AA55CC, 3 waitrequest cycles → read_data_memory 0xFFFFFF80; lbu same → 0x00000080; stall lasts 5 cycles.
- sh 0x1234 @0x202 → byteenable 1100, writedata 0x12341234; lhu @0x202 with readdata 0xBEEF0000 → 0x0000BEEF.
- lwl @0x001 with rt=0x11223344, d=0xAABBCCDD → 0xCCDD3344; lwr @0x001 same inputs → 0x11AABBCC.
- lw @0x006 → address_error pulse, no avm_read, read_data_memory 0, stall released after 2 cycles; with WAIT_TIMEOUT=4 and waitrequest stuck high → bus_timeout after 4 REQ cycles.
- Assert reset during REQ with waitrequest=1 → avm_read=0 immediately, state IDLE, memory_stall follows the inputs on the next cycle.
